// File: rtl/neuron_lut_scheduler.sv
// Time-multiplexes NUM_NEURONS lookups onto one shared combinational LUT.
// Define NEURON_LUT_SCHED_PERF_EN to add job_count/busy_cycles counters.
module neuron_lut_scheduler #(
    parameter int NUM_NEURONS = 16,
    parameter int IN_BITS     = 6,
    parameter int OUT_BITS    = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            flush,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [NUM_NEURONS*IN_BITS-1:0]  in_data,
    output logic [$clog2(NUM_NEURONS)-1:0]  lut_sel,
    output logic [IN_BITS-1:0]              lut_addr,
    input  logic [OUT_BITS-1:0]             lut_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [NUM_NEURONS*OUT_BITS-1:0] out_data
`ifdef NEURON_LUT_SCHED_PERF_EN
    ,
    output logic [15:0]                     job_count,
    output logic [31:0]                     busy_cycles
`endif
);

    localparam int SW = $clog2(NUM_NEURONS);
    localparam logic [SW-1:0] LAST = SW'(NUM_NEURONS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t                         state_q;
    state_t                         state_d;
    logic [SW-1:0]                  idx_q;
    logic [NUM_NEURONS*IN_BITS-1:0] cap_q;
    logic                           accept;
    logic                           last;

    assign accept = in_valid & in_ready;
    assign last   = (idx_q == LAST);

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        lut_sel   = '0;
        lut_addr  = '0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = RUN;
            end
            RUN: begin
                lut_sel  = idx_q;
                lut_addr = cap_q[idx_q*IN_BITS +: IN_BITS];
                if (last) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // flush wins over any handshake in the same cycle
        if (flush) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            cap_q    <= '0;
            out_data <= '0;
        end else begin
            state_q <= state_d;
            if (flush) begin
                idx_q    <= '0;
                out_data <= '0;
            end else if (accept) begin
                cap_q    <= in_data;
                idx_q    <= '0;
                out_data <= '0;
            end else if (state_q == RUN) begin
                out_data[idx_q*OUT_BITS +: OUT_BITS] <= lut_data;
                idx_q <= last ? '0 : idx_q + 1'b1;
            end
        end
    end

`ifdef NEURON_LUT_SCHED_PERF_EN
    logic deliver;

    assign deliver = out_valid & out_ready & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            job_count   <= '0;
            busy_cycles <= '0;
        end else begin
            if (deliver) job_count <= job_count + 16'd1;
            if (state_q != IDLE && busy_cycles != '1)
                busy_cycles <= busy_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_neuron_lut_scheduler.sv
// Randomized self-checking bench for neuron_lut_scheduler.
// Expected results come from a lookup-table model of the neuron array.
`timescale 1ns/1ps
module tb_neuron_lut_scheduler;

    localparam int NN = 16;
    localparam int IB = 6;
    localparam int OB = 2;
    localparam int SW = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              out_ready = 1'b0;
    logic              in_ready;
    logic              out_valid;
    logic [NN*IB-1:0]  in_data = '0;
    logic [SW-1:0]     lut_sel;
    logic [IB-1:0]     lut_addr;
    logic [OB-1:0]     lut_data;
    logic [NN*OB-1:0]  out_data;
`ifdef NEURON_LUT_SCHED_PERF_EN
    logic [15:0]       job_count;
    logic [31:0]       busy_cycles;
`endif

    logic [OB-1:0] tab [NN][1<<IB];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign lut_data = tab[lut_sel][lut_addr];

    neuron_lut_scheduler #(
        .NUM_NEURONS(NN),
        .IN_BITS(IB),
        .OUT_BITS(OB)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .flush(flush),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .lut_sel(lut_sel),
        .lut_addr(lut_addr),
        .lut_data(lut_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data)
`ifdef NEURON_LUT_SCHED_PERF_EN
        ,
        .job_count(job_count),
        .busy_cycles(busy_cycles)
`endif
    );

    // mode 0: random table, 1: out = addr[1:0], 2: all ones
    task automatic fill_tab(input int mode);
        for (int k = 0; k < NN; k++)
            for (int a = 0; a < (1 << IB); a++)
                tab[k][a] = (mode == 1) ? OB'(a) :
                            (mode == 2) ? OB'(3) : OB'($urandom);
    endtask

    function automatic logic [NN*IB-1:0] rand_data();
        logic [NN*IB-1:0] d;
        for (int k = 0; k < NN; k++) d[k*IB +: IB] = IB'($urandom);
        return d;
    endfunction

    function automatic logic [NN*OB-1:0] model(input logic [NN*IB-1:0] d);
        logic [NN*OB-1:0] r;
        r = '0;
        for (int k = 0; k < NN; k++) r[k*OB +: OB] = tab[k][d[k*IB +: IB]];
        return r;
    endfunction

    task automatic start_job(input logic [NN*IB-1:0] d);
        @(negedge clk);
        in_data  = d;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output bit ok);
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        ok = (out_valid === 1'b1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || lut_sel !== '0 || lut_addr !== '0) begin
            errors++;
            $display("FAIL reset_state: out_valid=%b out_data=%h lut_sel=%0d lut_addr=%0d, want 0",
                     out_valid, out_data, lut_sel, lut_addr);
        end
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_single_job();
        logic [NN*IB-1:0] d;
        logic [NN*OB-1:0] e;
        fill_tab(1);
        for (int k = 0; k < NN; k++) begin
            d[k*IB +: IB] = IB'(k);
            e[k*OB +: OB] = OB'(k % 4);
        end
        start_job(d);
        for (int k = 0; k < NN; k++) begin
            checks++;
            if (lut_sel !== SW'(k) || lut_addr !== IB'(k) || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL single_walk[%0d]: sel=%0d addr=%0d out_valid=%b want sel=%0d addr=%0d valid=0",
                         k, lut_sel, lut_addr, out_valid, k, k);
            end
            @(posedge clk);
            @(negedge clk);
        end
        checks++;
        if (out_valid !== 1'b1 || out_data !== e || in_ready !== 1'b0 || lut_sel !== '0) begin
            errors++;
            $display("FAIL single_done: valid=%b data=%h ready=%b sel=%0d want valid=1 data=%h ready=0 sel=0",
                     out_valid, out_data, in_ready, lut_sel, e);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_handshake: valid=%b ready=%b want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_backpressure();
        logic [NN*IB-1:0] d;
        logic [NN*OB-1:0] e;
        bit ok;
        fill_tab(0);
        d = rand_data();
        e = model(d);
        start_job(d);
        wait_valid(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL bp_timeout: out_valid=%b want 1", out_valid);
        end
        // a competing input must be ignored while busy
        in_valid = 1'b1;
        in_data  = rand_data();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== e || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: valid=%b data=%h ready=%b want 1/%h/0",
                         i, out_valid, out_data, in_ready, e);
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || lut_sel !== '0) begin
            errors++;
            $display("FAIL bp_release: valid=%b ready=%b sel=%0d want 0/1/0",
                     out_valid, in_ready, lut_sel);
        end
    endtask

    task automatic test_flush();
        logic [NN*IB-1:0] d;
        logic [NN*OB-1:0] e;
        bit ok;
        bit seen;
        fill_tab(0);
        start_job(rand_data());
        repeat (7) @(negedge clk);
        checks++;
        if (lut_sel !== SW'(7)) begin
            errors++;
            $display("FAIL flush_idx: sel=%0d want 7", lut_sel);
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || lut_sel !== '0) begin
            errors++;
            $display("FAIL flush_idle: ready=%b valid=%b sel=%0d want 1/0/0",
                     in_ready, out_valid, lut_sel);
        end
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid !== 1'b0) seen = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL flush_no_output: out_valid seen=1 want 0");
        end
        in_valid = 1'b1;
        flush    = 1'b1;
        in_data  = rand_data();
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || lut_sel !== '0) begin
            errors++;
            $display("FAIL flush_over_accept: ready=%b sel=%0d want 1/0", in_ready, lut_sel);
        end
        d = rand_data();
        e = model(d);
        start_job(d);
        wait_valid(ok);
        checks++;
        if (!ok || out_data !== e) begin
            errors++;
            $display("FAIL flush_next_job: valid=%b data=%h want 1/%h", out_valid, out_data, e);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        fill_tab(2);
        start_job(rand_data());
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || lut_sel !== '0) begin
            errors++;
            $display("FAIL arst_immediate: valid=%b data=%h sel=%0d want 0/0/0",
                     out_valid, out_data, lut_sel);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL arst_release: ready=%b valid=%b want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [NN*OB-1:0] exp_q[$];
        int  last_acc;
        int  cyc;
        int  jobs_out;
        bit  acc;
        bit  hs;
        fill_tab(0);
        last_acc = -1;
        cyc      = 0;
        jobs_out = 0;
        @(negedge clk);
        in_data   = rand_data();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        while (jobs_out < 4 && cyc < 200) begin
            acc = (in_ready === 1'b1);
            hs  = (out_valid === 1'b1);
            if (hs) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_spurious: out_valid=1 with no job pending");
                end else begin
                    if (out_data !== exp_q[0]) begin
                        errors++;
                        $display("FAIL b2b_data[%0d]: got %h want %h", jobs_out, out_data, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
                jobs_out++;
            end
            if (acc) begin
                if (last_acc >= 0) begin
                    checks++;
                    if (cyc - last_acc != 18) begin
                        errors++;
                        $display("FAIL b2b_spacing: got %0d cycles want 18", cyc - last_acc);
                    end
                end
                last_acc = cyc;
                exp_q.push_back(model(in_data));
            end
            @(negedge clk);
            cyc++;
            if (acc) in_data = rand_data();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (jobs_out != 4) begin
            errors++;
            $display("FAIL b2b_timeout: completed %0d jobs want 4", jobs_out);
        end
    endtask

`ifdef NEURON_LUT_SCHED_PERF_EN
    task automatic test_perf();
        bit ok;
        test_reset();
        checks++;
        if (job_count !== 16'd0 || busy_cycles !== 32'd0) begin
            errors++;
            $display("FAIL perf_reset: jobs=%0d busy=%0d want 0/0", job_count, busy_cycles);
        end
        fill_tab(0);
        for (int j = 0; j < 3; j++) begin
            start_job(rand_data());
            wait_valid(ok);
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (job_count !== 16'd3 || busy_cycles !== 32'd51) begin
            errors++;
            $display("FAIL perf_counts: jobs=%0d busy=%0d want 3/51", job_count, busy_cycles);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_job();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_back_to_back();
`ifdef NEURON_LUT_SCHED_PERF_EN
        test_perf();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
